// File: rtl/approx_mult_error_profiler.sv
// Exhaustive error profiler for an unsigned approximate multiplier: sweeps every
// operand pair, compares z_in with the exact product and accumulates error metrics.
module approx_mult_error_profiler #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     x_out,
    output logic [W-1:0]     y_out,
    input  logic [2*W-1:0]   z_in,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [2*W:0]     err_count,
    output logic [4*W-1:0]   sum_abs_err,
    output logic [2*W-1:0]   max_abs_err,
    output logic [W-1:0]     worst_x,
    output logic [W-1:0]     worst_y
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic   start_act, abort_act, done_nxt, last_pair, acc_en;

    logic             vld_p1;
    logic [W-1:0]     x_p1, y_p1;
    logic [2*W-1:0]   z_p1, exact_p1, abs_p1;

    function automatic logic [2*W-1:0] abs_diff(input logic [2*W-1:0] a,
                                                input logic [2*W-1:0] b);
        logic signed [2*W:0] d;
        logic signed [2*W:0] neg;
        d   = $signed({1'b0, a}) - $signed({1'b0, b});
        neg = -d;
        return d[2*W] ? neg[2*W-1:0] : d[2*W-1:0];
    endfunction

    assign last_pair = (x_out == {W{1'b1}}) && (y_out == {W{1'b1}});
    assign busy      = (state == SWEEP) || (state == DRAIN);
    assign acc_en    = vld_p1 && !abort_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_act = 1'b0;
        abort_act = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    start_act = 1'b1;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    abort_act = 1'b1;
                end else if (last_pair) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    abort_act = 1'b1;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand generator: {x,y} as one counter gives y inner, x outer; holds at the last pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out        <= '0;
            y_out        <= '0;
            vld_p1       <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            done   <= done_nxt;
            vld_p1 <= (state == SWEEP) && !abort;
            if (start_act) begin
                x_out        <= '0;
                y_out        <= '0;
                result_valid <= 1'b0;
            end else begin
                if ((state == SWEEP) && !abort && !last_pair) begin
                    {x_out, y_out} <= {x_out, y_out} + 1'b1;
                end
                if (done_nxt) begin
                    result_valid <= 1'b1;
                end
            end
        end
    end

    // Stage 1: capture the presented pair and its approximate product
    always_ff @(posedge clk) begin
        x_p1 <= x_out;
        y_p1 <= y_out;
        z_p1 <= z_in;
    end

    assign exact_p1 = {{W{1'b0}}, x_p1} * {{W{1'b0}}, y_p1};
    assign abs_p1   = abs_diff(z_p1, exact_p1);

    // Stage 2: accumulate; strict compare keeps the earliest pair on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            worst_x     <= '0;
            worst_y     <= '0;
        end else if (start_act) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            worst_x     <= '0;
            worst_y     <= '0;
        end else if (acc_en) begin
            err_count   <= err_count + {{(2*W){1'b0}}, (abs_p1 != '0)};
            sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, abs_p1};
            if (abs_p1 > max_abs_err) begin
                max_abs_err <= abs_p1;
                worst_x     <= x_p1;
                worst_y     <= y_p1;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_error_profiler.sv
// Directed bench for approx_mult_error_profiler at W=4 with selectable multiplier stubs.
module tb_approx_mult_error_profiler;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [W-1:0]     x_out, y_out;
    logic [2*W-1:0]   z_in;
    logic             busy, done, result_valid;
    logic [2*W:0]     err_count;
    logic [4*W-1:0]   sum_abs_err;
    logic [2*W-1:0]   max_abs_err;
    logic [W-1:0]     worst_x, worst_y;

    logic [2*W-1:0]   ex_tb;
    int               mode = 0;
    int               checks = 0;
    int               failures = 0;

    typedef struct {
        int     mode;
        string  name;
        longint e_err;
        longint e_sum;
        longint e_max;
        longint e_wx;
        longint e_wy;
    } vec_t;

    vec_t vecs[5];

    approx_mult_error_profiler #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_out(x_out), .y_out(y_out), .z_in(z_in),
        .busy(busy), .done(done), .result_valid(result_valid),
        .err_count(err_count), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .worst_x(worst_x), .worst_y(worst_y)
    );

    always #5 clk = ~clk;

    // Multiplier stubs: exact, +1, zero, low-bit truncation, all-ones
    assign ex_tb = {{W{1'b0}}, x_out} * {{W{1'b0}}, y_out};
    always_comb begin
        z_in = ex_tb;
        case (mode)
            1: z_in = ex_tb + 1'b1;
            2: z_in = '0;
            3: z_in = {ex_tb[2*W-1:1], 1'b0};
            4: z_in = '1;
            default: z_in = ex_tb;
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Starts a sweep, waits for done, checks latency, pulse width and metrics
    task automatic run_vec(input int idx);
        int lat;
        lat = 0;
        mode = vecs[idx].mode;
        pulse_start();
        check({vecs[idx].name, "_busy_start"}, busy, 1);
        for (int c = 1; c <= N + 20 && lat == 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        check({vecs[idx].name, "_latency"}, lat, N + 1);
        check({vecs[idx].name, "_busy_done"}, busy, 0);
        check({vecs[idx].name, "_result_valid"}, result_valid, 1);
        check({vecs[idx].name, "_err_count"}, err_count, vecs[idx].e_err);
        check({vecs[idx].name, "_sum_abs_err"}, sum_abs_err, vecs[idx].e_sum);
        check({vecs[idx].name, "_max_abs_err"}, max_abs_err, vecs[idx].e_max);
        check({vecs[idx].name, "_worst_x"}, worst_x, vecs[idx].e_wx);
        check({vecs[idx].name, "_worst_y"}, worst_y, vecs[idx].e_wy);
        @(negedge clk);
        check({vecs[idx].name, "_done_one_cycle"}, done, 0);
        check({vecs[idx].name, "_result_hold"}, result_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int ndone;

        vecs[0] = '{0, "exact", 0,   0,     0,   0,  0};
        vecs[1] = '{1, "plus1", 256, 256,   1,   0,  0};
        vecs[2] = '{2, "zero",  225, 14400, 225, 15, 15};
        vecs[3] = '{3, "trunc", 64,  64,    1,   1,  1};
        vecs[4] = '{4, "ones",  256, 50880, 255, 0,  0};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_x", x_out, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Operand order; a start pulse mid-sweep must not restart the counters
        mode = 0;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            check("order_x", x_out, k >> W);
            check("order_y", y_out, k % (1 << W));
            start = (k == 20);
        end
        start = 1'b0;
        c = 39;
        while (!done && c < N + 50) begin
            @(negedge clk);
            c++;
        end
        check("order_latency", c, N + 1);
        check("order_result_valid", result_valid, 1);
        check("order_err_count", err_count, 0);
        repeat (3) @(negedge clk);
        check("hold_x", x_out, (1 << W) - 1);
        check("hold_y", y_out, (1 << W) - 1);

        // Abort 100 cycles in
        mode = 2;
        pulse_start();
        check("abort_rv_cleared", result_valid, 0);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result_valid", result_valid, 0);
        ndone = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_rv_after", result_valid, 0);

        // Abort and start together during a sweep: abort wins
        pulse_start();
        repeat (10) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abort_start_idle", busy, 0);
        run_vec(0);

        // Reset mid-sweep after metrics have accumulated
        mode = 2;
        pulse_start();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_x", x_out, 0);
        check("mrst_y", y_out, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_result_valid", result_valid, 0);
        check("mrst_err_count", err_count, 0);
        check("mrst_sum", sum_abs_err, 0);
        check("mrst_max", max_abs_err, 0);
        check("mrst_worst_x", worst_x, 0);
        check("mrst_worst_y", worst_y, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
